// File: rtl/wb_pkg.sv
// Shared write-back stage encodings and the stage-register payload layout.
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_type_e;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] wreg;
        logic [1:0]        wb_sel;
        logic [2:0]        ld_type;
        logic [1:0]        byte_off;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   link_addr;
    } wb_payload_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction: picks the byte/halfword lane and extends it.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  byte_off,
    output logic [31:0] ld_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata[7:0];
        case (byte_off)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
    end

    // Halfword lane ignores byte_off[0]; misalignment is trapped upstream.
    assign lane_h = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        case (ld_type)
            LD_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            LD_BU:   ld_data = {24'd0, lane_b};
            LD_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            LD_HU:   ld_data = {16'd0, lane_h};
            default: ld_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: one stage register feeding the register-file write port.
module wb_stage
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] alu_res,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] link_addr,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  byte_off,
    input  logic        regwrite,
    input  logic [4:0]  wreg,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_valid
);

    wb_payload_t d;
    wb_payload_t q;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        d           = '0;
        d.valid     = in_valid;
        d.regwrite  = regwrite;
        d.wreg      = wreg;
        d.wb_sel    = wb_sel;
        d.ld_type   = ld_type;
        d.byte_off  = byte_off;
        d.alu_res   = alu_res;
        d.mem_rdata = mem_rdata;
        d.link_addr = link_addr;
    end

    // Flush kills the entering instruction even while stalled; data fields are don't-care then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid    <= 1'b0;
            q.regwrite <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

    load_align u_load_align (
        .mem_rdata (q.mem_rdata),
        .ld_type   (q.ld_type),
        .byte_off  (q.byte_off),
        .ld_data   (ld_data)
    );

    always_comb begin
        rf_wdata = q.alu_res;
        case (q.wb_sel)
            WB_MEM:  rf_wdata = ld_data;
            WB_LINK: rf_wdata = q.link_addr;
            default: rf_wdata = q.alu_res;
        endcase
    end

    assign rf_waddr = q.wreg;
    assign wb_valid = q.valid;
    assign rf_we    = q.valid & q.regwrite & (q.wreg != 5'd0);

endmodule

// File: tb/tb_wb_stage.sv
// Directed + light random bench for wb_stage with an expected-result queue.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, in_valid, regwrite;
    logic [31:0] alu_res, mem_rdata, link_addr;
    logic [1:0]  wb_sel, byte_off;
    logic [2:0]  ld_type;
    logic [4:0]  wreg;
    logic        rf_we, wb_valid;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        valid;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];

    wb_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .alu_res   (alu_res),
        .mem_rdata (mem_rdata),
        .link_addr (link_addr),
        .wb_sel    (wb_sel),
        .ld_type   (ld_type),
        .byte_off  (byte_off),
        .regwrite  (regwrite),
        .wreg      (wreg),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_valid  (wb_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference load extraction written with shifts rather than lane cases.
    function automatic logic [31:0] model_load(logic [31:0] mem, logic [2:0] ld, logic [1:0] off);
        logic [31:0] sb_w, sh_w;
        sb_w = mem >> (8 * int'(off));
        sh_w = mem >> (off[1] ? 16 : 0);
        case (ld)
            3'd1:    return {{24{sb_w[7]}}, sb_w[7:0]};
            3'd2:    return {24'd0, sb_w[7:0]};
            3'd3:    return {{16{sh_w[15]}}, sh_w[15:0]};
            3'd4:    return {16'd0, sh_w[15:0]};
            default: return mem;
        endcase
    endfunction

    task automatic cmp(string tag, string fld, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(string tag, logic we, logic [4:0] wa, logic [31:0] wd, logic v, bit cd = 1'b1);
        exp_t e;
        e.tag = tag; e.we = we; e.waddr = wa; e.wdata = wd; e.valid = v; e.chk_data = cd;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "rf_we", 32'(rf_we), 32'(e.we));
            cmp(e.tag, "wb_valid", 32'(wb_valid), 32'(e.valid));
            if (e.chk_data) begin
                cmp(e.tag, "rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                cmp(e.tag, "rf_wdata", rf_wdata, e.wdata);
            end
        end
    endtask

    task automatic drive(logic v, logic rw, logic [4:0] wr, logic [1:0] sel, logic [2:0] ld,
                         logic [1:0] off, logic [31:0] alu, logic [31:0] mem, logic [31:0] lnk);
        in_valid = v; regwrite = rw; wreg = wr; wb_sel = sel; ld_type = ld;
        byte_off = off; alu_res = alu; mem_rdata = mem; link_addr = lnk;
    endtask

    // Drive at the falling edge, sample one time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic [31:0] rmem;
        logic [2:0]  rld;
        logic [1:0]  roff, rsel;
        logic [4:0]  rwr;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 5'd9, 2'b00, 3'd0, 2'd0, 32'hCAFE_0001, 32'h0, 32'h0);
        #2;
        push("reset_hold", 0, 5'd0, 32'd0, 0);
        pop_check();
        @(posedge clk); #1;
        push("reset_edge", 0, 5'd0, 32'd0, 0);
        pop_check();
        @(negedge clk); rst_n = 1'b1;
        drive(0, 0, 5'd0, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        push("post_reset_idle", 0, 5'd0, 32'd0, 0);
        step();

        @(negedge clk);
        drive(1, 1, 5'd5, 2'b00, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 32'h0);
        push("alu_write", 1, 5'd5, 32'h0000_1234, 1);
        step();

        @(negedge clk);
        drive(1, 1, 5'd6, 2'b01, 3'd1, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0);
        push("lb_off3", 1, 5'd6, 32'hFFFF_FF80, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd6, 2'b01, 3'd2, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0);
        push("lbu_off3", 1, 5'd6, 32'h0000_0080, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd6, 2'b01, 3'd1, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0);
        push("lb_off1", 1, 5'd6, 32'h0000_007F, 1);
        step();

        @(negedge clk);
        drive(1, 1, 5'd8, 2'b01, 3'd3, 2'd2, 32'h0, 32'h8001_7FFF, 32'h0);
        push("lh_off2", 1, 5'd8, 32'hFFFF_8001, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd8, 2'b01, 3'd4, 2'd2, 32'h0, 32'h8001_7FFF, 32'h0);
        push("lhu_off2", 1, 5'd8, 32'h0000_8001, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd8, 2'b01, 3'd3, 2'd1, 32'h0, 32'h8001_7FFF, 32'h0);
        push("lh_off1", 1, 5'd8, 32'h0000_7FFF, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd8, 2'b01, 3'd6, 2'd3, 32'h0, 32'h8001_7FFF, 32'h0);
        push("ld_rsvd_lw", 1, 5'd8, 32'h8001_7FFF, 1);
        step();

        @(negedge clk);
        drive(1, 1, 5'd0, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        push("r0_suppress", 0, 5'd0, 32'hDEAD_BEEF, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd31, 2'b10, 3'd0, 2'd0, 32'h1111_1111, 32'h0, 32'h0040_0008);
        push("link_write", 1, 5'd31, 32'h0040_0008, 1);
        step();
        @(negedge clk);
        drive(1, 1, 5'd12, 2'b11, 3'd0, 2'd0, 32'h5555_AAAA, 32'h1, 32'h2);
        push("sel_rsvd_alu", 1, 5'd12, 32'h5555_AAAA, 1);
        step();
        @(negedge clk);
        drive(1, 0, 5'd12, 2'b00, 3'd0, 2'd0, 32'h7, 32'h0, 32'h0);
        push("no_regwrite", 0, 5'd12, 32'h7, 1);
        step();

        // Instruction A held under a 3-cycle stall while B waits at the input.
        @(negedge clk);
        drive(1, 1, 5'd7, 2'b00, 3'd0, 2'd0, 32'hAAAA_0007, 32'h0, 32'h0);
        push("stall_A", 1, 5'd7, 32'hAAAA_0007, 1);
        step();
        @(negedge clk);
        stall = 1'b1;
        drive(1, 1, 5'd9, 2'b10, 3'd0, 2'd0, 32'hBBBB_0009, 32'h0, 32'hBBBB_1009);
        for (int i = 0; i < 3; i++) begin
            push($sformatf("stall_hold%0d", i), 1, 5'd7, 32'hAAAA_0007, 1);
            step();
        end
        @(negedge clk);
        stall = 1'b0;
        push("stall_release_B", 1, 5'd9, 32'hBBBB_1009, 1);
        step();
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        drive(1, 1, 5'd10, 2'b00, 3'd0, 2'd0, 32'hCCCC_000A, 32'h0, 32'h0);
        push("flush_over_stall", 0, 5'd0, 32'd0, 0, 1'b0);
        step();
        @(negedge clk);
        stall = 1'b0; flush = 1'b1;
        push("flush_only", 0, 5'd0, 32'd0, 0, 1'b0);
        step();
        @(negedge clk);
        flush = 1'b0;
        push("after_flush", 1, 5'd10, 32'hCCCC_000A, 1);
        step();

        // Asynchronous reset landing mid-cycle while a stalled write is held.
        @(negedge clk);
        drive(1, 1, 5'd20, 2'b00, 3'd0, 2'd0, 32'hE000_0014, 32'h0, 32'h0);
        push("pre_reset_E", 1, 5'd20, 32'hE000_0014, 1);
        step();
        @(negedge clk);
        stall = 1'b1;
        push("stalled_E", 1, 5'd20, 32'hE000_0014, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        push("async_reset", 0, 5'd0, 32'd0, 0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        drive(0, 1, 5'd21, 2'b00, 3'd0, 2'd0, 32'h0000_0015, 32'h0, 32'h0);
        push("post_reset_bubble", 0, 5'd21, 32'h0000_0015, 0);
        step();
        @(negedge clk);
        drive(1, 1, 5'd22, 2'b00, 3'd0, 2'd0, 32'h0000_0016, 32'h0, 32'h0);
        push("post_reset_write", 1, 5'd22, 32'h0000_0016, 1);
        step();

        // Random loads/ALU/link writes against the shift-based model.
        for (int i = 0; i < 12; i++) begin
            rmem = $urandom;
            rld  = 3'($urandom_range(0, 7));
            roff = 2'($urandom_range(0, 3));
            rsel = 2'($urandom_range(0, 2));
            rwr  = 5'($urandom_range(1, 31));
            @(negedge clk);
            drive(1, 1, rwr, rsel, rld, roff, ~rmem, rmem, rmem ^ 32'h0F0F_0F0F);
            push($sformatf("rand%0d", i), 1, rwr,
                 (rsel == 2'b01) ? model_load(rmem, rld, roff) :
                 (rsel == 2'b10) ? (rmem ^ 32'h0F0F_0F0F) : ~rmem, 1);
            step();
        end

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
